// File: rtl/game_seq_pkg.sv
// Shared encodings and default timing constants for the game sequencer.
package game_seq_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;
    localparam logic [2:0] INPUT = 3'd5;
    localparam logic [2:0] EVAL  = 3'd6;
    localparam logic [2:0] LEVEL = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_ARM   = ARM,
        S_START = START,
        S_READ  = READ,
        S_CLEAR = CLEAR,
        S_INPUT = INPUT,
        S_EVAL  = EVAL,
        S_LEVEL = LEVEL
    } state_e;

    localparam int unsigned ROUND_MAX = 255;

    localparam int unsigned DEF_READ_CYCLES   = 100_000_000;
    localparam int unsigned DEF_INPUT_CYCLES  = 250_000_000;
    localparam int unsigned DEF_EVAL_CYCLES   = 50_000_000;
    localparam int unsigned DEF_LEVEL_TIMEOUT = 4096;
    localparam int unsigned DEF_TIMER_W       = 28;

    // A phase of N cycles loads N-1; a zero-length phase still lasts one cycle.
    function automatic int unsigned cycles_to_load(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Key/datapath-facing signals of the game sequencer; master is the sequencer, slave the board side.
interface game_sequencer_if;

    logic       go;
    logic       submit;
    logic       pause;
    logic       level_draw_comp;
    logic       ld_start;
    logic       ld_read;
    logic       ld_reset;
    logic       ld_input;
    logic       ld_evaluate;
    logic       ld_level;
    logic [2:0] state_code;
    logic [7:0] round_count;
    logic       level_timeout;

    modport master (
        input  go, submit, pause, level_draw_comp,
        output ld_start, ld_read, ld_reset, ld_input, ld_evaluate, ld_level,
        output state_code, round_count, level_timeout
    );

    modport slave (
        output go, submit, pause, level_draw_comp,
        input  ld_start, ld_read, ld_reset, ld_input, ld_evaluate, ld_level,
        input  state_code, round_count, level_timeout
    );

endinterface

// File: rtl/game_sequencer_cycle_timer.sv
// Down-counter shared by all timed phases: load N-1 on entry, done when the count reaches zero.
module cycle_timer #(
    parameter int unsigned TIMER_W = 28
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Moore sequencer for the pattern-memory game: steps the datapath load strobes through each phase.
// Define GAME_SEQ_PAUSE_EN to let pause freeze READ/INPUT/EVAL and the LEVEL watchdog.
module game_sequencer
    import game_seq_pkg::*;
#(
    parameter int unsigned READ_CYCLES   = DEF_READ_CYCLES,
    parameter int unsigned INPUT_CYCLES  = DEF_INPUT_CYCLES,
    parameter int unsigned EVAL_CYCLES   = DEF_EVAL_CYCLES,
    parameter int unsigned LEVEL_TIMEOUT = DEF_LEVEL_TIMEOUT,
    parameter int unsigned TIMER_W       = DEF_TIMER_W
) (
    input logic              clock,
    input logic              reset,
    game_sequencer_if.master bus
);

    localparam logic [TIMER_W-1:0] READ_LD  = TIMER_W'(cycles_to_load(READ_CYCLES));
    localparam logic [TIMER_W-1:0] INPUT_LD = TIMER_W'(cycles_to_load(INPUT_CYCLES));
    localparam logic [TIMER_W-1:0] EVAL_LD  = TIMER_W'(cycles_to_load(EVAL_CYCLES));
    localparam logic [TIMER_W-1:0] LEVEL_LD = TIMER_W'(cycles_to_load(LEVEL_TIMEOUT));
    localparam logic [7:0]         ROUND_SAT = 8'(ROUND_MAX);

    state_e             state_q, state_d;
    logic [7:0]         round_q, round_d;
    logic               timeout_q, timeout_d;
    logic               t_load;
    logic [TIMER_W-1:0] t_value;
    logic               t_done;
    logic               hold;

`ifdef GAME_SEQ_PAUSE_EN
    assign hold = bus.pause && (state_q inside {S_READ, S_INPUT, S_EVAL, S_LEVEL});
`else
    logic unused_pause;
    assign unused_pause = bus.pause;
    assign hold         = 1'b0;
`endif

    cycle_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (t_load),
        .load_value (t_value),
        .enable     (!hold),
        .done       (t_done)
    );

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE:  if (bus.go) state_d = S_ARM;
            S_ARM:   if (!bus.go) state_d = S_START;
            S_START: state_d = S_READ;
            S_READ:  if (!hold && t_done) state_d = S_CLEAR;
            S_CLEAR: state_d = S_INPUT;
            S_INPUT: if (!hold && (bus.submit || t_done)) state_d = S_EVAL;
            S_EVAL:  if (!hold && t_done) state_d = S_LEVEL;
            S_LEVEL: begin
                // A completed draw wins over a watchdog expiry in the same cycle.
                if (bus.level_draw_comp) begin
                    state_d = S_START;
                    if (round_q != ROUND_SAT) round_d = round_q + 8'd1;
                end else if (!hold && t_done) begin
                    state_d   = S_START;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The timer is reloaded only on a state change, so it holds N-1 in a phase's first cycle.
    always_comb begin
        t_load  = (state_d != state_q);
        t_value = '0;
        case (state_d)
            S_READ:  t_value = READ_LD;
            S_INPUT: t_value = INPUT_LD;
            S_EVAL:  t_value = EVAL_LD;
            S_LEVEL: t_value = LEVEL_LD;
            default: t_value = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            round_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        bus.ld_start    = 1'b0;
        bus.ld_read     = 1'b0;
        bus.ld_reset    = 1'b0;
        bus.ld_input    = 1'b0;
        bus.ld_evaluate = 1'b0;
        bus.ld_level    = 1'b0;
        case (state_q)
            S_START: bus.ld_start    = 1'b1;
            S_READ:  bus.ld_read     = 1'b1;
            S_CLEAR: bus.ld_reset    = 1'b1;
            S_INPUT: bus.ld_input    = 1'b1;
            S_EVAL:  bus.ld_evaluate = 1'b1;
            S_LEVEL: bus.ld_level    = 1'b1;
            default: ;
        endcase
    end

    assign bus.state_code    = state_q;
    assign bus.round_count   = round_q;
    assign bus.level_timeout = timeout_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer: expected phase runs are queued, a monitor checks them.
module tb_game_sequencer;

    localparam int RD_C = 4;
    localparam int IN_C = 8;
    localparam int EV_C = 3;
    localparam int LV_T = 6;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_ARM   = 3'd1;
    localparam logic [2:0] C_START = 3'd2;
    localparam logic [2:0] C_READ  = 3'd3;
    localparam logic [2:0] C_CLEAR = 3'd4;
    localparam logic [2:0] C_INPUT = 3'd5;
    localparam logic [2:0] C_EVAL  = 3'd6;
    localparam logic [2:0] C_LEVEL = 3'd7;

    // One expected run: a state held for len cycles (0 = any length) with the given status outputs.
    typedef struct {
        logic [2:0] code;
        int         len;
        int         rc;
        int         to;
    } run_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    game_sequencer_if bus ();

    game_sequencer #(
        .READ_CYCLES   (RD_C),
        .INPUT_CYCLES  (IN_C),
        .EVAL_CYCLES   (EV_C),
        .LEVEL_TIMEOUT (LV_T),
        .TIMER_W       (28)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_errors = 0;
    run_t exp_q[$];
    int   m_rc = 0;
    int   m_to = 0;
    bit   mon_en = 1'b0;
    bit   aborted = 1'b0;

    logic [2:0] cur_code;
    int         cur_len;
    int         cur_rc;
    int         cur_to;
    bit         have_run = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] code, input int len, input int rc, input int to);
        run_t r;
        r.code = code;
        r.len  = len;
        r.rc   = rc;
        r.to   = to;
        exp_q.push_back(r);
    endtask

    task automatic close_run();
        run_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_run_code", 64'(cur_code), 64'd8);
            return;
        end
        e = exp_q.pop_front();
        check("run_code", 64'(cur_code), 64'(e.code));
        if (e.len != 0) check($sformatf("run_len_s%0d", e.code), 64'(cur_len), 64'(e.len));
        check($sformatf("run_rounds_s%0d", e.code), 64'(cur_rc), 64'(e.rc));
        check($sformatf("run_timeout_s%0d", e.code), 64'(cur_to), 64'(e.to));
    endtask

    // Monitor: per-cycle strobe decode check and run-length tracking, sampled on the falling edge.
    always @(negedge clock) begin
        logic [5:0] ld;
        logic [5:0] ld_exp;
        if (mon_en) begin
            ld = {bus.ld_start, bus.ld_read, bus.ld_reset, bus.ld_input, bus.ld_evaluate, bus.ld_level};
            case (bus.state_code)
                C_START: ld_exp = 6'b100000;
                C_READ:  ld_exp = 6'b010000;
                C_CLEAR: ld_exp = 6'b001000;
                C_INPUT: ld_exp = 6'b000100;
                C_EVAL:  ld_exp = 6'b000010;
                C_LEVEL: ld_exp = 6'b000001;
                default: ld_exp = 6'b000000;
            endcase
            check("ld_strobes", 64'(ld), 64'(ld_exp));
            if (have_run && (bus.state_code == cur_code)) begin
                cur_len++;
            end else begin
                if (have_run) close_run();
                cur_code = bus.state_code;
                cur_len  = 1;
                cur_rc   = int'(bus.round_count);
                cur_to   = int'(bus.level_timeout);
                have_run = 1'b1;
            end
        end
    end

    task automatic wait_code(input logic [2:0] code, input bit want);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((bus.state_code == code) == want) return;
        end
        n_checks++;
        n_errors++;
        aborted = 1'b1;
        $display("FAIL wait_state: state_code %0d never %s %0d", bus.state_code,
                 want ? "reached" : "left", code);
    endtask

    task automatic press_go();
        push(C_ARM, 2, m_rc, m_to);
        bus.go = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.go = 1'b0;
    endtask

    // One full round; ks = INPUT cycle carrying submit (outside 1..IN_C: none),
    // kc = LEVEL cycle carrying level_draw_comp (outside 1..LV_T: none), pn = pause cycles in READ.
    task automatic run_round(input int ks, input int kc, input int pn);
        int in_len;
        bit hit;
        in_len = (ks >= 1 && ks <= IN_C) ? ks : IN_C;
        hit    = (kc >= 1 && kc <= LV_T);
        push(C_START, 1, m_rc, m_to);
        push(C_READ, RD_C + pn, m_rc, m_to);
        push(C_CLEAR, 1, m_rc, m_to);
        push(C_INPUT, in_len, m_rc, m_to);
        push(C_EVAL, EV_C, m_rc, m_to);
        push(C_LEVEL, hit ? kc : LV_T, m_rc, m_to);
        if (hit) m_rc = (m_rc == 255) ? 255 : m_rc + 1;
        else     m_to = 1;
        if (pn > 0) begin
            wait_code(C_READ, 1'b1);
            bus.pause = 1'b1;
            repeat (pn) @(negedge clock);
            bus.pause = 1'b0;
        end
        wait_code(C_INPUT, 1'b1);
        if (ks >= 1 && ks <= IN_C) begin
            repeat (ks - 1) @(negedge clock);
            bus.submit = 1'b1;
            @(negedge clock);
            bus.submit = 1'b0;
        end
        wait_code(C_LEVEL, 1'b1);
        if (hit) begin
            repeat (kc - 1) @(negedge clock);
            bus.level_draw_comp = 1'b1;
            @(negedge clock);
            bus.level_draw_comp = 1'b0;
        end else begin
            wait_code(C_LEVEL, 1'b0);
        end
    endtask

    initial begin
        #800_000;
        n_errors++;
        $display("FAIL global_timeout: bench did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int n;
        int sat;
        int ks;
        int kc;
        bus.go              = 1'b0;
        bus.submit          = 1'b0;
        bus.pause           = 1'b0;
        bus.level_draw_comp = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_state", 64'(bus.state_code), 64'(C_IDLE));
        check("reset_ld", 64'({bus.ld_start, bus.ld_read, bus.ld_reset, bus.ld_input,
                               bus.ld_evaluate, bus.ld_level}), 64'd0);
        check("reset_rounds", 64'(bus.round_count), 64'd0);
        check("reset_timeout", 64'(bus.level_timeout), 64'd0);
        reset = 1'b0;
        push(C_IDLE, 0, 0, 0);
        mon_en = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_hold_state", 64'(bus.state_code), 64'(C_IDLE));

        press_go();
        run_round(0, 2, 0);
        check("round_after_first", 64'(bus.round_count), 64'd1);
        run_round(3, 2, 0);
        run_round(5, 0, 0);
        check("timeout_flag", 64'(bus.level_timeout), 64'd1);
        check("timeout_rounds", 64'(bus.round_count), 64'd2);

        n   = 0;
        sat = 0;
        while (sat < 3 && n < 400 && !aborted) begin
            ks = int'($urandom_range(0, 9));
            kc = int'($urandom_range(0, 6));
            if (kc != 0 && m_rc == 255) sat++;
            run_round(ks, kc, 0);
            n++;
        end
        check("rounds_saturated", 64'(bus.round_count), 64'd255);
        check("timeout_sticky", 64'(bus.level_timeout), 64'd1);

        push(C_START, 1, m_rc, m_to);
        push(C_READ, 2, m_rc, m_to);
        push(C_IDLE, 0, 0, 0);
        wait_code(C_READ, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midread_reset_state", 64'(bus.state_code), 64'(C_IDLE));
        check("midread_reset_ld", 64'({bus.ld_start, bus.ld_read, bus.ld_reset, bus.ld_input,
                                       bus.ld_evaluate, bus.ld_level}), 64'd0);
        check("midread_reset_rounds", 64'(bus.round_count), 64'd0);
        check("midread_reset_timeout", 64'(bus.level_timeout), 64'd0);
        reset = 1'b0;
        m_rc  = 0;
        m_to  = 0;
        @(negedge clock);

        press_go();
`ifdef GAME_SEQ_PAUSE_EN
        run_round(3, 1, 5);
`else
        run_round(int'($urandom_range(1, 8)), 4, 0);
`endif
        check("post_reset_round", 64'(bus.round_count), 64'd1);

        push(C_START, 1, m_rc, m_to);
        push(C_IDLE, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        mon_en = 1'b0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
